// File: rtl/ahb_burst_arbiter_pkg.sv
// ahb_burst_arbiter_pkg: AHB burst types and beat-limit helper shared by the slave-port arbiters
package ahb_burst_arbiter_pkg;
  typedef enum logic [2:0] {SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16} hburst_type;
  // INCR has no defined length, so it is capped at max_incr beats
  function automatic logic [7:0] burst_limit(hburst_type b, int max_incr);
    return b == SINGLE ? 8'd0 :
           b == INCR ? 8'(max_incr - 1) :
           b inside {WRAP4, INCR4} ? 8'd3 :
           b inside {WRAP8, INCR8} ? 8'd7 : 8'd15;
  endfunction
endpackage

// File: rtl/ahb_burst_arbiter_rr_pick.sv
// ahb_rr_pick: picks the first set request at or after base (base forced to 0 in fixed-priority mode)
module ahb_rr_pick #(
  parameter int N = 4,
  parameter int W = 2,
  parameter bit RR = 1'b1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] base_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o
);
  logic [W-1:0] base;
  logic [W-1:0] k;
  assign base = RR ? base_i : '0;
  // scan backwards so the closest requester to base is the last one written
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    k = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = W'((int'(base) + i) % N);
      if (req_i[k]) begin
        gnt_o = '0;
        gnt_o[k] = 1'b1;
        idx_o = k;
      end
    end
  end
endmodule

// File: rtl/ahb_burst_arbiter.sv
// ahb_burst_arbiter: per-slave AHB arbiter holding the grant for a whole burst with zero-bubble handover
module ahb_burst_arbiter
  import ahb_burst_arbiter_pkg::*;
#(
  parameter int MASTER_NUM = 4,
  parameter bit RR_MODE = 1'b1,
  parameter int MAX_INCR = 16,
  parameter int MIDX_W = MASTER_NUM > 1 ? $clog2(MASTER_NUM) : 1
) (
  input  logic                       hclk,
  input  logic                       hreset_n,
  input  logic [MASTER_NUM-1:0]      hreq,
  input  logic [MASTER_NUM-1:0][2:0] hburst,
  input  logic                       hwait,
  output logic [MASTER_NUM-1:0]      hgrant,
  output logic [MIDX_W-1:0]          hmaster,
  output logic                       hsel,
  output logic                       hlast
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;
  logic [0:0] state_q, state_d;
  logic [7:0] count_q, count_d, limit_q, limit_d;
  logic [MIDX_W-1:0] last_q, last_d, own_q, own_d, base, pick_idx;
  logic [MASTER_NUM-1:0] gnt_q, gnt_d, pick_gnt;
  logic done, rel, arb, any_req;
  assign hgrant = gnt_q;
  assign hmaster = own_q;
  assign hsel = |gnt_q;
  assign done = hsel & ~hwait;
  // a withdrawn request ends the burst at the current beat boundary
  assign rel = done & (count_q == limit_q | ~hreq[own_q]);
  assign hlast = rel;
  assign arb = state_q == IDLE | rel;
  assign any_req = |hreq;
  assign base = last_q == MIDX_W'(MASTER_NUM - 1) ? '0 : last_q + MIDX_W'(1);
  ahb_rr_pick #(.N(MASTER_NUM), .W(MIDX_W), .RR(RR_MODE)) u_pick (
    .req_i  (hreq),
    .base_i (base),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx)
  );
  always_comb begin
    state_d = arb ? (any_req ? OWN : IDLE) : state_q;
    gnt_d = arb ? pick_gnt : gnt_q;
    own_d = arb ? pick_idx : own_q;
    last_d = arb & any_req ? pick_idx : last_q;
    limit_d = arb & any_req ? burst_limit(hburst_type'(hburst[pick_idx]), MAX_INCR) : limit_q;
    count_d = arb ? '0 : count_q + 8'(done);
  end
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      limit_q <= '0;
      last_q <= MIDX_W'(MASTER_NUM - 1);
      own_q <= '0;
      gnt_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      last_q <= last_d;
      own_q <= own_d;
      gnt_q <= gnt_d;
    end
  end
endmodule

// File: tb/tb_ahb_burst_arbiter.sv
// tb_ahb_burst_arbiter: round-robin and fixed-priority instances on shared stimulus, checked against a burst-level model
module tb_ahb_burst_arbiter;
  import ahb_burst_arbiter_pkg::*;
  localparam int N = 4;
  localparam int MI = 16;
  logic hclk = 1'b0;
  logic hreset_n = 1'b0;
  logic hwait = 1'b0;
  logic [N-1:0] hreq = '0;
  logic [N-1:0][2:0] hburst = '0;
  logic [N-1:0] g_rr, g_fx;
  logic [1:0] m_rr, m_fx;
  logic s_rr, s_fx, l_rr, l_fx;
  int n_cmp = 0;
  int n_bad = 0;
  int own[2], cnt[2], lim[2], last[2];
  bit busy[2];
  int lim_tab[8] = '{0, MI - 1, 3, 3, 7, 7, 15, 15};

  always #5 hclk = ~hclk;

  ahb_burst_arbiter #(.MASTER_NUM(N), .RR_MODE(1'b1), .MAX_INCR(MI)) u_rr (
    .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hburst(hburst), .hwait(hwait),
    .hgrant(g_rr), .hmaster(m_rr), .hsel(s_rr), .hlast(l_rr)
  );
  ahb_burst_arbiter #(.MASTER_NUM(N), .RR_MODE(1'b0), .MAX_INCR(MI)) u_fix (
    .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hburst(hburst), .hwait(hwait),
    .hgrant(g_fx), .hmaster(m_fx), .hsel(s_fx), .hlast(l_fx)
  );

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  // model: index 0 is the round-robin instance, 1 the fixed-priority one
  initial begin
    int w, j, eg;
    bit el;
    string p;
    forever begin
      @(negedge hclk);
      for (int m = 0; m < 2; m++) begin
        p = m == 0 ? "rr_" : "fx_";
        if (!hreset_n) begin
          busy[m] = 0; own[m] = 0; cnt[m] = 0; lim[m] = 0; last[m] = N - 1;
        end
        eg = busy[m] ? (1 << own[m]) : 0;
        el = busy[m] && !hwait && (cnt[m] == lim[m] || !hreq[own[m]]);
        chk({p, "hgrant"}, m == 0 ? int'(g_rr) : int'(g_fx), eg);
        chk({p, "hmaster"}, m == 0 ? int'(m_rr) : int'(m_fx), busy[m] ? own[m] : 0);
        chk({p, "hsel"}, m == 0 ? int'(s_rr) : int'(s_fx), int'(busy[m]));
        chk({p, "hlast"}, m == 0 ? int'(l_rr) : int'(l_fx), int'(el));
        if (hreset_n) begin
          if (!busy[m] || el) begin
            w = -1;
            for (int k = 1; k <= N; k++) begin
              j = m == 0 ? (last[m] + k) % N : k - 1;
              if (w < 0 && hreq[j]) w = j;
            end
            busy[m] = w >= 0;
            cnt[m] = 0;
            if (w >= 0) begin
              own[m] = w; last[m] = w; lim[m] = lim_tab[hburst[w]];
            end
          end else if (!hwait) cnt[m]++;
        end
      end
    end
  end

  initial begin
    int held, hl, lc;
    repeat (2) @(negedge hclk);
    chk("rst_hgrant", int'(g_rr), 0);
    chk("rst_hsel", int'(s_fx), 0);
    // fixed priority from idle
    step(); hreset_n = 1'b1; hreq = 4'b1010;
    step(); @(negedge hclk);
    chk("t1_fx_hgrant", int'(g_fx), 4'b0010);
    chk("t1_fx_hmaster", int'(m_fx), 1);
    chk("t1_rr_hgrant", int'(g_rr), 4'b0010);
    step(); hreq = '0; repeat (3) step();
    // round-robin rotation with SINGLE bursts
    hreq = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step(); @(negedge hclk);
      chk("t2_rr_hmaster", int'(m_rr), i % 4);
      chk("t2_rr_hlast", int'(l_rr), 1);
      chk("t2_fx_hmaster", int'(m_fx), 0);
    end
    step(); hreq = '0; repeat (3) step();
    // INCR8 on master 2 with a 3-cycle stall, master 3 waiting
    hburst[2] = INCR8; hreq = 4'b0100; held = 0; hl = 0; lc = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      hwait = i >= 4 && i <= 6;
      if (i == 1) hreq = 4'b1100;
      @(negedge hclk);
      if (g_rr == 4'b0100) begin
        held++;
        if (l_rr) begin hl++; lc = i; end
      end
    end
    chk("t3_held", held, 11);
    chk("t3_hlast_cnt", hl, 1);
    chk("t3_hlast_cyc", lc, 11);
    chk("t3_next", int'(g_rr), 4'b1000);
    step(); hreq = '0; hwait = 1'b0; repeat (3) step();
    // INCR capped at MAX_INCR beats
    hburst[0] = INCR; hburst[1] = SINGLE; hreq = 4'b0011; held = 0; hl = 0; lc = 0;
    for (int i = 1; i <= 17; i++) begin
      step(); @(negedge hclk);
      if (g_rr == 4'b0001) begin
        held++;
        if (l_rr) begin hl++; lc = i; end
      end
      if (i == 16) chk("t4_fx_hlast", int'(l_fx), 1);
    end
    chk("t4_held", held, 16);
    chk("t4_hlast_cnt", hl, 1);
    chk("t4_hlast_cyc", lc, 16);
    chk("t4_next", int'(m_rr), 1);
    chk("t4_fx_next", int'(g_fx), 4'b0001);
    step(); hreq = '0; repeat (3) step();
    // stall on the final beat of INCR4, new request arrives during the stall
    hburst[1] = INCR4; hburst[3] = SINGLE; hreq = 4'b0010;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 4) begin hwait = 1'b1; hreq = 4'b1010; end
      if (i == 5) hwait = 1'b0;
      @(negedge hclk);
      if (i == 4) begin
        chk("t7_stall_hlast", int'(l_rr), 0);
        chk("t7_stall_hgrant", int'(g_rr), 4'b0010);
      end
      if (i == 5) begin
        chk("t7_rr_hlast", int'(l_rr), 1);
        chk("t7_fx_hlast", int'(l_fx), 1);
      end
      if (i == 6) begin
        chk("t7_rr_next", int'(g_rr), 4'b1000);
        chk("t7_fx_next", int'(g_fx), 4'b0010);
      end
    end
    step(); hreq = '0; repeat (3) step();
    // master 0 withdraws after 2 beats of INCR4
    hburst[0] = INCR4; hburst[2] = SINGLE; hreq = 4'b0001;
    for (int i = 1; i <= 3; i++) begin
      step();
      if (i == 2) hreq = 4'b0100;
      @(negedge hclk);
      if (i == 1) begin
        chk("t5_rr_hgrant", int'(g_rr), 4'b0001);
        chk("t5_rr_hlast1", int'(l_rr), 0);
      end
      if (i == 2) begin
        chk("t5_rr_hlast2", int'(l_rr), 1);
        chk("t5_fx_hlast2", int'(l_fx), 1);
      end
      if (i == 3) begin
        chk("t5_rr_next", int'(g_rr), 4'b0100);
        chk("t5_fx_next", int'(g_fx), 4'b0100);
      end
    end
    step(); hreq = '0; repeat (3) step();
    // reset during beat 5 of WRAP16
    hburst[2] = WRAP16; hreq = 4'b0100;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 4) begin
        @(negedge hclk);
        chk("t6_owner", int'(g_rr), 4'b0100);
      end
    end
    #1 hreset_n = 1'b0;
    #1;
    chk("t6_rst_hgrant", int'(g_rr), 0);
    chk("t6_rst_hsel", int'(s_rr), 0);
    chk("t6_rst_hmaster", int'(m_rr), 0);
    chk("t6_rst_hlast", int'(l_rr), 0);
    chk("t6_rst_fx_hgrant", int'(g_fx), 0);
    hburst = '0;
    repeat (2) step();
    hreset_n = 1'b1; hreq = 4'b1111;
    step(); @(negedge hclk);
    chk("t6_rr_first", int'(g_rr), 4'b0001);
    chk("t6_rr_first_hmaster", int'(m_rr), 0);
    step(); hreq = '0; repeat (4) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
